// File: rtl/regs_arbiter_if.sv
// Bundle between the two register-file clients, the arbiter and the register file.
// The slave side is the arbiter; the master side is the clients plus the register file.
interface regs_arbiter_if #(
    parameter int n = 8
);
    logic         req_a, req_b;
    logic         we_a, we_b;
    logic [1:0]   rdno_a, rdno_b;
    logic [1:0]   rsno_a, rsno_b;
    logic [n-1:0] wdata_a, wdata_b;
    logic         lock_a, lock_b;
    logic         gnt_a, gnt_b;
    logic         rvalid_a, rvalid_b;
    logic [n-1:0] rd_data_a, rd_data_b;
    logic [n-1:0] rs_data_a, rs_data_b;
    logic         rf_w;
    logic [n-1:0] rf_wdata;
    logic [1:0]   rf_rdno, rf_rsno;
    logic [n-1:0] rf_rd, rf_rs;

    modport slave (
        input  req_a, req_b, we_a, we_b, rdno_a, rdno_b, rsno_a, rsno_b,
        input  wdata_a, wdata_b, lock_a, lock_b,
        output gnt_a, gnt_b, rvalid_a, rvalid_b,
        output rd_data_a, rd_data_b, rs_data_a, rs_data_b,
        output rf_w, rf_wdata, rf_rdno, rf_rsno,
        input  rf_rd, rf_rs
    );

    modport master (
        output req_a, req_b, we_a, we_b, rdno_a, rdno_b, rsno_a, rsno_b,
        output wdata_a, wdata_b, lock_a, lock_b,
        input  gnt_a, gnt_b, rvalid_a, rvalid_b,
        input  rd_data_a, rd_data_b, rs_data_a, rs_data_b,
        input  rf_w, rf_wdata, rf_rdno, rf_rsno,
        output rf_rd, rf_rs
    );
endinterface

// File: rtl/regs_arbiter.sv
// Two-client arbiter for the 4-entry register file: round-robin with lock,
// one issue stage onto the register-file ports, one response stage back to the winner.
module regs_arbiter #(
    parameter int n = 8
) (
    input  logic          clk,
    input  logic          reset,
    regs_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_A    = 2'd1,
        LOCK_B    = 2'd2
    } lock_e;

    lock_e        lock_q, lock_d;
    logic         last_b_q, last_b_d;
    logic         elig_a, elig_b;
    logic         gnt_a, gnt_b;

    logic         vld_p1_q, vld_p1_d;
    logic         cli_b_p1_q, cli_b_p1_d;
    logic         rf_w_p1_q, rf_w_p1_d;
    logic [n-1:0] rf_wdata_p1_q, rf_wdata_p1_d;
    logic [1:0]   rf_rdno_p1_q, rf_rdno_p1_d;
    logic [1:0]   rf_rsno_p1_q, rf_rsno_p1_d;

    logic         rvalid_a_p2_q, rvalid_a_p2_d;
    logic         rvalid_b_p2_q, rvalid_b_p2_d;
    logic [n-1:0] rd_data_a_p2_q, rd_data_a_p2_d;
    logic [n-1:0] rs_data_a_p2_q, rs_data_a_p2_d;
    logic [n-1:0] rd_data_b_p2_q, rd_data_b_p2_d;
    logic [n-1:0] rs_data_b_p2_q, rs_data_b_p2_d;

    // Stage p0: arbitration. A lock owner shuts the other client out even when idle.
    always_comb begin
        elig_a = !reset && bus.req_a && (lock_q != LOCK_B);
        elig_b = !reset && bus.req_b && (lock_q != LOCK_A);
        gnt_a  = elig_a && (!elig_b || last_b_q);
        gnt_b  = elig_b && !gnt_a;
    end

    always_comb begin
        last_b_d = last_b_q;
        lock_d   = lock_q;
        if (lock_q == LOCK_A && !bus.lock_a) lock_d = LOCK_NONE;
        if (lock_q == LOCK_B && !bus.lock_b) lock_d = LOCK_NONE;
        if (gnt_a) begin
            last_b_d = 1'b0;
            if (bus.lock_a) lock_d = LOCK_A;
        end
        if (gnt_b) begin
            last_b_d = 1'b1;
            if (bus.lock_b) lock_d = LOCK_B;
        end
    end

    // Stage p1: issue. Idle cycles keep the last addresses/data and drop the write enable.
    always_comb begin
        vld_p1_d      = gnt_a || gnt_b;
        cli_b_p1_d    = gnt_b;
        rf_w_p1_d     = 1'b0;
        rf_wdata_p1_d = rf_wdata_p1_q;
        rf_rdno_p1_d  = rf_rdno_p1_q;
        rf_rsno_p1_d  = rf_rsno_p1_q;
        if (gnt_a) begin
            rf_w_p1_d     = bus.we_a;
            rf_wdata_p1_d = bus.wdata_a;
            rf_rdno_p1_d  = bus.rdno_a;
            rf_rsno_p1_d  = bus.rsno_a;
        end else if (gnt_b) begin
            rf_w_p1_d     = bus.we_b;
            rf_wdata_p1_d = bus.wdata_b;
            rf_rdno_p1_d  = bus.rdno_b;
            rf_rsno_p1_d  = bus.rsno_b;
        end
    end

    // Stage p2: capture pre-write read data at the same edge the write lands.
    always_comb begin
        rvalid_a_p2_d  = vld_p1_q && !cli_b_p1_q;
        rvalid_b_p2_d  = vld_p1_q && cli_b_p1_q;
        rd_data_a_p2_d = rvalid_a_p2_d ? bus.rf_rd : rd_data_a_p2_q;
        rs_data_a_p2_d = rvalid_a_p2_d ? bus.rf_rs : rs_data_a_p2_q;
        rd_data_b_p2_d = rvalid_b_p2_d ? bus.rf_rd : rd_data_b_p2_q;
        rs_data_b_p2_d = rvalid_b_p2_d ? bus.rf_rs : rs_data_b_p2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q         <= LOCK_NONE;
            last_b_q       <= 1'b1;
            vld_p1_q       <= 1'b0;
            cli_b_p1_q     <= 1'b0;
            rf_w_p1_q      <= 1'b0;
            rf_wdata_p1_q  <= '0;
            rf_rdno_p1_q   <= '0;
            rf_rsno_p1_q   <= '0;
            rvalid_a_p2_q  <= 1'b0;
            rvalid_b_p2_q  <= 1'b0;
            rd_data_a_p2_q <= '0;
            rs_data_a_p2_q <= '0;
            rd_data_b_p2_q <= '0;
            rs_data_b_p2_q <= '0;
        end else begin
            lock_q         <= lock_d;
            last_b_q       <= last_b_d;
            vld_p1_q       <= vld_p1_d;
            cli_b_p1_q     <= cli_b_p1_d;
            rf_w_p1_q      <= rf_w_p1_d;
            rf_wdata_p1_q  <= rf_wdata_p1_d;
            rf_rdno_p1_q   <= rf_rdno_p1_d;
            rf_rsno_p1_q   <= rf_rsno_p1_d;
            rvalid_a_p2_q  <= rvalid_a_p2_d;
            rvalid_b_p2_q  <= rvalid_b_p2_d;
            rd_data_a_p2_q <= rd_data_a_p2_d;
            rs_data_a_p2_q <= rs_data_a_p2_d;
            rd_data_b_p2_q <= rd_data_b_p2_d;
            rs_data_b_p2_q <= rs_data_b_p2_d;
        end
    end

    assign bus.gnt_a     = gnt_a;
    assign bus.gnt_b     = gnt_b;
    // Reset during the issue cycle must suppress the write that is already on the port.
    assign bus.rf_w      = rf_w_p1_q && !reset;
    assign bus.rf_wdata  = rf_wdata_p1_q;
    assign bus.rf_rdno   = rf_rdno_p1_q;
    assign bus.rf_rsno   = rf_rsno_p1_q;
    assign bus.rvalid_a  = rvalid_a_p2_q;
    assign bus.rvalid_b  = rvalid_b_p2_q;
    assign bus.rd_data_a = rd_data_a_p2_q;
    assign bus.rs_data_a = rs_data_a_p2_q;
    assign bus.rd_data_b = rd_data_b_p2_q;
    assign bus.rs_data_b = rs_data_b_p2_q;
endmodule

// File: tb/tb_regs_arbiter.sv
// Scoreboard bench for regs_arbiter: per-client command queues drive requests, a
// grant-order reference model predicts grants and responses, a monitor checks rvalids.
module tb_regs_arbiter;
    localparam int n = 8;

    typedef struct {
        logic         we;
        logic [1:0]   rdno;
        logic [1:0]   rsno;
        logic [n-1:0] wdata;
        logic         lock;
    } cmd_t;

    typedef struct {
        int           cyc;
        int           cli;
        logic [n-1:0] rd;
        logic [n-1:0] rs;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    regs_arbiter_if #(.n(n)) bus();
    regs_arbiter #(.n(n)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Register file the arbiter drives.
    logic [n-1:0] rf [4];
    always @(posedge clk) if (bus.rf_w) rf[bus.rf_rdno] <= bus.rf_wdata;
    assign bus.rf_rd = rf[bus.rf_rdno];
    assign bus.rf_rs = rf[bus.rf_rsno];

    // Reference model state.
    logic [n-1:0] mem [4];
    int           owner = -1;
    int           last = 1;
    logic         lock_hold [2];
    logic         drv_lock [2];
    cmd_t         qa[$];
    cmd_t         qb[$];
    exp_t         sb[$];
    logic         rst_v = 1'b1;
    logic         e_rf_w = 1'b0;
    logic [n-1:0] e_rf_wdata = '0;
    logic [1:0]   e_rf_rdno = '0;
    logic [1:0]   e_rf_rsno = '0;
    logic         pw_v = 1'b0;
    logic [1:0]   pw_addr = '0;
    logic [n-1:0] pw_old = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic we, input logic [1:0] rdno, input logic [1:0] rsno,
                                input logic [n-1:0] wdata, input logic lock);
        cmd_t c;
        c.we = we; c.rdno = rdno; c.rsno = rsno; c.wdata = wdata; c.lock = lock;
        return c;
    endfunction

    function automatic int pick();
        bit ra = qa.size() != 0;
        bit rb = qb.size() != 0;
        if (owner == 0) return ra ? 0 : -1;
        if (owner == 1) return rb ? 1 : -1;
        if (ra && rb) return (last == 1) ? 0 : 1;
        if (ra) return 0;
        if (rb) return 1;
        return -1;
    endfunction

    task automatic drive();
        bus.req_a = qa.size() != 0;
        bus.req_b = qb.size() != 0;
        if (qa.size() != 0) begin
            bus.we_a = qa[0].we; bus.rdno_a = qa[0].rdno; bus.rsno_a = qa[0].rsno;
            bus.wdata_a = qa[0].wdata; bus.lock_a = qa[0].lock;
        end else bus.lock_a = lock_hold[0];
        if (qb.size() != 0) begin
            bus.we_b = qb[0].we; bus.rdno_b = qb[0].rdno; bus.rsno_b = qb[0].rsno;
            bus.wdata_b = qb[0].wdata; bus.lock_b = qb[0].lock;
        end else bus.lock_b = lock_hold[1];
        drv_lock[0] = bus.lock_a;
        drv_lock[1] = bus.lock_b;
    endtask

    task automatic step();
        int   w;
        cmd_t c;
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst_v;
        drive();
        #1;
        w = rst_v ? -1 : pick();
        chk("gnt_a", 32'(bus.gnt_a), 32'(w == 0));
        chk("gnt_b", 32'(bus.gnt_b), 32'(w == 1));
        chk("rf_w", 32'(bus.rf_w), 32'(rst_v ? 1'b0 : e_rf_w));
        chk("rf_rdno", 32'(bus.rf_rdno), 32'(e_rf_rdno));
        chk("rf_rsno", 32'(bus.rf_rsno), 32'(e_rf_rsno));
        chk("rf_wdata", 32'(bus.rf_wdata), 32'(e_rf_wdata));
        if (rst_v) begin
            if (pw_v) mem[pw_addr] = pw_old;
            pw_v = 1'b0;
            e_rf_w = 1'b0; e_rf_wdata = '0; e_rf_rdno = '0; e_rf_rsno = '0;
            owner = -1; last = 1;
            lock_hold[0] = 1'b0; lock_hold[1] = 1'b0;
            while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
        end else begin
            pw_v = 1'b0;
            e_rf_w = 1'b0;
            if (owner >= 0 && !drv_lock[owner]) owner = -1;
            if (w >= 0) begin
                c = (w == 0) ? qa.pop_front() : qb.pop_front();
                e.cyc = cyc + 2; e.cli = w; e.rd = mem[c.rdno]; e.rs = mem[c.rsno];
                sb.push_back(e);
                if (c.we) begin
                    pw_v = 1'b1; pw_addr = c.rdno; pw_old = mem[c.rdno];
                    mem[c.rdno] = c.wdata;
                end
                e_rf_w = c.we; e_rf_wdata = c.wdata; e_rf_rdno = c.rdno; e_rf_rsno = c.rsno;
                last = w;
                if (c.lock) owner = w;
                lock_hold[w] = c.lock;
            end
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        lock_hold[0] = 1'b0;
        lock_hold[1] = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (qa.size() == 0 && qb.size() == 0 && sb.size() == 0) begin
                done = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout cycle %0d: qa=%0d qb=%0d sb=%0d left, required 0",
                     cyc, qa.size(), qb.size(), sb.size());
            qa.delete(); qb.delete(); sb.delete();
        end
    endtask

    // Response monitor.
    always @(negedge clk) begin
        exp_t e;
        if (bus.rvalid_a || bus.rvalid_b) begin
            chk("rvalid_exclusive", 32'(bus.rvalid_a && bus.rvalid_b), 32'(0));
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL rvalid_unexpected cycle %0d: got rvalid_a=%0b rvalid_b=%0b, required none",
                         cyc, bus.rvalid_a, bus.rvalid_b);
            end else begin
                e = sb.pop_front();
                chk("rv_cycle", 32'(cyc), 32'(e.cyc));
                chk("rv_client", 32'(bus.rvalid_b), 32'(e.cli));
                chk("rd_data", 32'(e.cli == 0 ? bus.rd_data_a : bus.rd_data_b), 32'(e.rd));
                chk("rs_data", 32'(e.cli == 0 ? bus.rs_data_a : bus.rs_data_b), 32'(e.rs));
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++; errors++;
            $display("FAIL rvalid_missing cycle %0d: got none, required client %0d due cycle %0d",
                     cyc, e.cli, e.cyc);
        end
    end

    initial begin
        rf[0] = 8'h07; rf[1] = 8'h01; rf[2] = 8'h02; rf[3] = 8'h03;
        mem[0] = 8'h07; mem[1] = 8'h01; mem[2] = 8'h02; mem[3] = 8'h03;
        lock_hold[0] = 1'b0; lock_hold[1] = 1'b0;
        bus.req_a = 1'b0; bus.we_a = 1'b0; bus.rdno_a = '0; bus.rsno_a = '0; bus.wdata_a = '0; bus.lock_a = 1'b0;
        bus.req_b = 1'b0; bus.we_b = 1'b0; bus.rdno_b = '0; bus.rsno_b = '0; bus.wdata_b = '0; bus.lock_b = 1'b0;

        // Reset with a request already pending: it must wait until reset drops.
        rst_v = 1'b1;
        qa.push_back(mk(1'b1, 2'd2, 2'd0, 8'h5A, 1'b0));
        qa.push_back(mk(1'b0, 2'd2, 2'd2, 8'h00, 1'b0));
        step();
        step();
        chk("reset_rvalid_a", 32'(bus.rvalid_a), 32'(0));
        chk("reset_rvalid_b", 32'(bus.rvalid_b), 32'(0));
        chk("reset_rd_data_a", 32'(bus.rd_data_a), 32'(0));
        chk("reset_rs_data_b", 32'(bus.rs_data_b), 32'(0));
        rst_v = 1'b0;
        drain();
        chk("r2_after_write", 32'(rf[2]), 32'h5A);

        // Simultaneous requests alternate.
        for (int i = 0; i < 2; i++) begin
            qa.push_back(mk(1'b0, 2'(i), 2'(i + 1), 8'h00, 1'b0));
            qb.push_back(mk(1'b0, 2'(i + 2), 2'(i), 8'h00, 1'b0));
        end
        drain();

        // B locks across a read-modify-write while A keeps requesting.
        qb.push_back(mk(1'b1, 2'd1, 2'd1, 8'h11, 1'b1));
        qb.push_back(mk(1'b0, 2'd1, 2'd1, 8'h00, 1'b1));
        qb.push_back(mk(1'b1, 2'd1, 2'd0, 8'h12, 1'b0));
        step();
        for (int i = 0; i < 3; i++) qa.push_back(mk(1'b0, 2'd1, 2'd1, 8'h00, 1'b0));
        drain();
        chk("r1_after_lock_seq", 32'(rf[1]), 32'h12);

        // Cross-client write then read in consecutive cycles.
        qa.push_back(mk(1'b1, 2'd3, 2'd3, 8'hFF, 1'b0));
        step();
        qb.push_back(mk(1'b0, 2'd3, 2'd3, 8'h00, 1'b0));
        drain();

        // Write returns the old contents; the following read sees the new ones.
        qa.push_back(mk(1'b1, 2'd0, 2'd0, 8'h33, 1'b0));
        qa.push_back(mk(1'b0, 2'd0, 2'd0, 8'h00, 1'b0));
        drain();

        // Reset lands in the issue cycle of a locked write.
        qa.push_back(mk(1'b1, 2'd3, 2'd3, 8'h9C, 1'b1));
        step();
        rst_v = 1'b1;
        step();
        step();
        rst_v = 1'b0;
        chk("r3_kept_over_reset", 32'(rf[3]), 32'hFF);
        qb.push_back(mk(1'b0, 2'd3, 2'd2, 8'h00, 1'b0));
        drain();
        qa.push_back(mk(1'b0, 2'd0, 2'd1, 8'h00, 1'b0));
        qb.push_back(mk(1'b0, 2'd2, 2'd3, 8'h00, 1'b0));
        drain();

        // Randomized traffic with locks and idle gaps.
        for (int i = 0; i < 400; i++) begin
            if (qa.size() < 2 && $urandom_range(99) < 55)
                qa.push_back(mk(1'($urandom_range(1)), 2'($urandom_range(3)), 2'($urandom_range(3)),
                                8'($urandom), $urandom_range(99) < 30));
            if (qb.size() < 2 && $urandom_range(99) < 55)
                qb.push_back(mk(1'($urandom_range(1)), 2'($urandom_range(3)), 2'($urandom_range(3)),
                                8'($urandom), $urandom_range(99) < 30));
            step();
        end
        drain();
        for (int r = 0; r < 4; r++) chk("rf_final", 32'(rf[r]), 32'(mem[r]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
